// File: rtl/fifo_sync_1w_2r.sv
// ---------------------------------------------------------------------------
// fifo_sync_1w_2r
// Synchronous FIFO with one write port and two read ports. The oldest two
// entries are shown first-word-fall-through on dataout0/dataout1, and the
// consumer may pop 0, 1 or 2 entries per cycle, always in order.
// Over-reads are clamped to the current occupancy. Writes that do not fit
// after this cycle's pops are dropped silently. All outputs come straight
// from registers, so there is no combinational path from the request inputs.
// ---------------------------------------------------------------------------
module fifo_sync_1w_2r #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         datain,
  input  logic                     wr_en,
  input  logic                     rd_en0,
  input  logic                     rd_en1,
  output logic [WIDTH-1:0]         dataout0,
  output logic [WIDTH-1:0]         dataout1,
  output logic                     valid0,
  output logic                     valid1,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Storage and pointers
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q,    cnt_d;

  // Per-cycle decisions
  logic [1:0]       pops;
  logic             push;
  logic [AW-1:0]    rd_ptr_p1;

  // Second read slot wraps from DEPTH-1 back to 0 by pointer truncation.
  assign rd_ptr_p1 = rd_ptr_q + AW'(1);

  // Pop/push decision and next-state pointers/occupancy.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    pops = 2'd0;
    if (rd_en0) begin
      if (rd_en1 && (cnt_q >= CW'(2))) begin
        pops = 2'd2;
      end else if (cnt_q != '0) begin
        pops = 2'd1;
      end
    end
    // A write into a full FIFO fits only when something leaves this cycle.
    push     = wr_en && ((cnt_q - CW'(pops)) < CW'(DEPTH));
    rd_ptr_d = rd_ptr_q + AW'(pops);
    wr_ptr_d = wr_ptr_q + AW'(push);
    cnt_d    = cnt_q - CW'(pops) + CW'(push);
  end

  // State registers and memory write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      // NOTE: the memory is reset on purpose: both read ports expose raw
      // slot contents even when not valid, and those must never be X.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= datain;
      end
    end
  end

  // Outputs are pure decodes of registered state.
  assign dataout0 = mem_q[rd_ptr_q];
  assign dataout1 = mem_q[rd_ptr_p1];
  assign valid0   = (cnt_q >= CW'(1));
  assign valid1   = (cnt_q >= CW'(2));
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign count    = cnt_q;

`ifndef SYNTHESIS
  // Occupancy must stay in range and agree with the pointer distance.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (cnt_q <= CW'(DEPTH));
      assert (AW'(wr_ptr_q - rd_ptr_q) == cnt_q[AW-1:0]);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_1w_2r.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_1w_2r
// Directed scenarios plus a random soak for the 1-write/2-read FIFO. A queue
// model tracks the live contents; a compare process checks the DUT against it
// on every falling edge, and literal expectations pin key points.
// ---------------------------------------------------------------------------
module tb_fifo_sync_1w_2r;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic              clk;
  logic              rst_n;
  logic [WIDTH-1:0]  datain;
  logic              wr_en;
  logic              rd_en0;
  logic              rd_en1;
  logic [WIDTH-1:0]  dataout0;
  logic [WIDTH-1:0]  dataout1;
  logic              valid0;
  logic              valid1;
  logic              empty;
  logic              full;
  logic [$clog2(DEPTH):0] count;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  logic [WIDTH-1:0] model_q [$];

  fifo_sync_1w_2r #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .datain   (datain),
    .wr_en    (wr_en),
    .rd_en0   (rd_en0),
    .rd_en1   (rd_en1),
    .dataout0 (dataout0),
    .dataout1 (dataout1),
    .valid0   (valid0),
    .valid1   (valid1),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive the inputs for the next edge.
  task automatic drive(input bit w, input logic [31:0] d, input bit r0, input bit r1);
    wr_en  = w;
    datain = d;
    rd_en0 = r0;
    rd_en1 = r1;
  endtask

  // Advance one edge and update the model from the specification's rules.
  task automatic tick();
    int req;
    int pops;
    int sz;
    @(posedge clk);
    sz   = model_q.size();
    req  = !rd_en0 ? 0 : (rd_en1 ? 2 : 1);
    pops = (req < sz) ? req : sz;
    for (int i = 0; i < pops; i++) void'(model_q.pop_front());
    if (wr_en && ((sz - pops) < DEPTH)) model_q.push_back(datain);
    #1;
  endtask

  task automatic step(input bit w, input logic [31:0] d, input bit r0, input bit r1);
    drive(w, d, r0, r1);
    tick();
  endtask

  // Every-cycle comparison against the queue model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_count", 32'(count), 32'(model_q.size()));
      check("m_empty", 32'(empty), 32'(model_q.size() == 0));
      check("m_full",  32'(full),  32'(model_q.size() == DEPTH));
      check("m_valid0", 32'(valid0), 32'(model_q.size() >= 1));
      check("m_valid1", 32'(valid1), 32'(model_q.size() >= 2));
      if (model_q.size() >= 1) check("m_dout0", dataout0, model_q[0]);
      if (model_q.size() >= 2) check("m_dout1", dataout1, model_q[1]);
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 32'h0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Reset then idle
    step(0, 32'h0, 0, 0);
    check("rst_empty",  32'(empty), 32'd1);
    check("rst_valid0", 32'(valid0), 32'd0);
    check("rst_valid1", 32'(valid1), 32'd0);
    check("rst_count",  32'(count), 32'd0);
    check("rst_dout0",  dataout0, 32'h0);
    check("rst_dout1",  dataout1, 32'h0);

    // Three writes, then a double pop
    step(1, 32'hA0, 0, 0);
    check("a_valid0", 32'(valid0), 32'd1);
    check("a_dout0",  dataout0, 32'hA0);
    check("a_valid1", 32'(valid1), 32'd0);
    step(1, 32'hA1, 0, 0);
    step(1, 32'hA2, 0, 0);
    check("a_count3", 32'(count), 32'd3);
    check("a_dout1",  dataout1, 32'hA1);
    step(0, 32'h0, 1, 1);
    check("a_count1", 32'(count), 32'd1);
    check("a_head",   dataout0, 32'hA2);

    // Mid-run reset with three entries held
    step(1, 32'hA3, 0, 0);
    step(1, 32'hA4, 0, 0);
    check("mr_count3", 32'(count), 32'd3);
    rst_n = 1'b0;
    model_q.delete();
    #1;
    check("mr_empty",  32'(empty), 32'd1);
    check("mr_count",  32'(count), 32'd0);
    check("mr_valid0", 32'(valid0), 32'd0);
    check("mr_valid1", 32'(valid1), 32'd0);
    check("mr_dout0",  dataout0, 32'h0);
    check("mr_dout1",  dataout1, 32'h0);
    drive(0, 32'h0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Fill, drop at full, push+pop at full, drain
    for (int i = 0; i < 4; i++) step(1, 32'hB0 + 32'(i), 0, 0);
    step(1, 32'hFF, 0, 0);
    check("f_full",  32'(full), 32'd1);
    check("f_count", 32'(count), 32'd4);
    step(1, 32'hB4, 1, 0);
    check("f_count_pp", 32'(count), 32'd4);
    check("f_head_pp",  dataout0, 32'hB1);
    for (int i = 0; i < 4; i++) begin
      check("f_drain", dataout0, 32'hB1 + 32'(i));
      step(0, 32'h0, 1, 0);
    end
    check("f_empty", 32'(empty), 32'd1);

    // Clamped over-reads and lone rd_en1
    step(1, 32'hC0, 0, 0);
    check("c_head", dataout0, 32'hC0);
    step(0, 32'h0, 1, 1);
    check("c_empty", 32'(empty), 32'd1);
    check("c_count", 32'(count), 32'd0);
    step(0, 32'h0, 1, 0);
    check("c_count_e", 32'(count), 32'd0);
    step(1, 32'hC1, 0, 0);
    step(1, 32'hC2, 0, 0);
    step(0, 32'h0, 0, 1);
    check("c_rd1_only", 32'(count), 32'd2);
    check("c_rd1_head", dataout0, 32'hC1);
    step(0, 32'h0, 1, 1);

    // Wrap: both pointers are at slot 0 here; advance them to slot 3
    step(1, 32'h10, 0, 0);
    step(1, 32'h11, 0, 0);
    step(1, 32'h12, 0, 0);
    step(0, 32'h0, 1, 1);
    step(0, 32'h0, 1, 0);
    step(1, 32'hD3, 0, 0);
    step(1, 32'hD0, 0, 0);
    check("w_dout0", dataout0, 32'hD3);
    check("w_dout1", dataout1, 32'hD0);
    step(0, 32'h0, 1, 1);
    check("w_count0", 32'(count), 32'd0);
    // No bypass: a pending write into an empty FIFO is not yet visible.
    drive(1, 32'hE1, 0, 0);
    #1;
    check("w_nobypass", 32'(valid0), 32'd0);
    tick();
    // Head at slot 1; slot 2 still holds stale 0x12 from the filler writes.
    check("w_slot1",   dataout0, 32'hE1);
    check("w_stale2",  dataout1, 32'h12);
    step(0, 32'h0, 1, 0);

    // Random soak
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_sync_1w_2r.md
Name: fifo_sync_1w_2r

Overview:
- Synchronous FIFO with one write port and two read ports. The consumer can pop 0, 1 or 2 entries per cycle, in strict order.
- Exposes the oldest two entries in first-word-fall-through style.
- Reader-side counterpart to the network's 2-write/1-read merge FIFO. Sits at router egress, where a dual-issue consumer drains a single-producer stream.

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 4, number of entries; power of two, >= 2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- datain  input  WIDTH  write data.
- wr_en  input  1  write request.
- rd_en0  input  1  pop head entry.
- rd_en1  input  1  pop second entry; honoured only together with rd_en0.
- dataout0  output  WIDTH  head (oldest) entry.
- dataout1  output  WIDTH  entry after head.
- valid0  output  1  dataout0 holds a live entry (cnt >= 1).
- valid1  output  1  dataout1 holds a live entry (cnt >= 2).
- empty  output  1  cnt == 0.
- full  output  1  cnt == DEPTH.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- State:
  - mem[DEPTH] of WIDTH bits.
  - wr_ptr, rd_ptr: $clog2(DEPTH) bits each; wrap naturally modulo DEPTH.
  - cnt: $clog2(DEPTH)+1 bits.
- Reset (async, rst_n low):
  - mem, wr_ptr, rd_ptr and cnt all cleared to 0.
  - Outputs: dataout0 = dataout1 = 0, valid0 = valid1 = 0, empty = 1, full = 0, count = 0.
  - Reset asserted mid-operation discards all contents immediately; first cycle after release behaves as an empty FIFO.
- Read data (combinational from registers):
  - dataout0 = mem[rd_ptr].
  - dataout1 = mem[rd_ptr+1 mod DEPTH].
  - Values shown while valid0/valid1 = 0 are don't-care for the consumer, but must be the stored memory contents; no X.
- Pop count, from the cycle-start cnt:
  - req = 0 if !rd_en0; 1 if rd_en0 & !rd_en1; 2 if rd_en0 & rd_en1.
  - rd_en1 alone: ignored, no pop, no state change from the read side.
  - pops = min(req, cnt). Over-reads are clamped silently: a request for 2 with cnt = 1 pops 1; any request with cnt = 0 pops 0.
- Write acceptance:
  - push = wr_en & ((cnt - pops) < DEPTH).
  - A write to a full FIFO is accepted in the same cycle as any effective pop; otherwise it is dropped silently.
  - Written data goes to mem[wr_ptr]; memory is not otherwise modified.
- Update each clock:
  - rd_ptr += pops.
  - wr_ptr += push.
  - cnt = cnt - pops + push.
- Latency and bypass:
  - Write to visibility: 1 cycle. An entry written at edge N appears on dataout0/1 after edge N, with valid0/valid1 updated together.
  - No bypass: a write into an empty FIFO is not visible in the same cycle and cannot be popped that cycle.
- Wrap-around:
  - dataout1 index wraps from DEPTH-1 to 0.
  - A double pop with rd_ptr = DEPTH-1 moves rd_ptr to 1.
- Simultaneous events:
  - Push + 2 pops with cnt = 2: cnt becomes 1, and the new entry becomes the head.
  - Push + 1 pop at full: cnt stays DEPTH.
- Flags are pure decodes of cnt, registered via cnt; no combinational path from rd_en*/wr_en to any output.
- Assertions (sim only):
  - cnt <= DEPTH.
  - cnt == (wr_ptr - rd_ptr) mod DEPTH, except when cnt = DEPTH with wr_ptr == rd_ptr.

Test Plan (DEPTH=4, WIDTH=32):
- Reset, then idle -> empty = 1, valid0 = valid1 = 0, count = 0, dataout0 = dataout1 = 0. Pulse rst_n low mid-run with cnt = 3 -> same values immediately.
- Write 0xA0, 0xA1, 0xA2 on consecutive cycles -> cycle after the first write: valid0 = 1, dataout0 = 0xA0, valid1 = 0. After the third write: count = 3, dataout1 = 0xA1. Then rd_en0 = rd_en1 = 1 for one cycle -> count = 1, dataout0 = 0xA2.
- Fill to 4 (0xB0..0xB3), then wr_en = 1 alone with 0xFF -> dropped: full = 1, count = 4. Then wr_en + rd_en0 with 0xB4 -> count = 4, dataout0 = 0xB1. Draining 4 singles yields 0xB1, 0xB2, 0xB3, 0xB4.
- With count = 1 (head 0xC0), assert rd_en0 = rd_en1 = 1 -> pops 1: empty = 1, count = 0. With count = 0, assert rd_en0 -> no change. With count = 2, assert rd_en1 alone -> no pop, count = 2.
- Wrap: drive rd_ptr to 3 with count = 2 (entries 0xD3 at slot 3, 0xD0 at slot 0) -> dataout0 = 0xD3, dataout1 = 0xD0. Double pop -> count = 0, next write lands in slot 1.
- Random soak, 10k cycles: random wr_en/rd_en0/rd_en1 checked against a queue model -> order preserved, no loss except drops predicted by the push rule, count always matches the model.
